// File: rtl/fact_rr_sched.sv
// Round-robin front end that shares one iterative factorial engine between
// NREQ requesters; one 32-bit multiply step per cycle, tagged result output.
module fact_rr_sched #(
    parameter int NREQ = 4,
    parameter int NW   = 4,
    parameter int RW   = 32,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*NW-1:0]   n_in,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic [RW-1:0]        result,
    output logic                 result_valid,
    output logic [IDW-1:0]       result_id
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;

    localparam logic [NW:0]     I_START  = 2;
    localparam logic [NREQ-1:0] ONEHOT_0 = 1;
    localparam logic [RW-1:0]   ACC_ONE  = 1;

    logic [0:0]    state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [NW-1:0] n_reg;
    // One extra bit so the loop ends cleanly for the largest operand.
    logic [NW:0]   i;
    logic [RW-1:0] acc;

    logic           found;
    logic [IDW-1:0] gidx;
    logic [IDW-1:0] ptr_next;
    logic [NW-1:0]  n_sel;
    int             j;

    // Rotating priority search starting at ptr.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                gidx  = IDW'(j);
            end
        end
    end

    assign n_sel    = n_in[gidx*NW +: NW];
    assign ptr_next = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    assign busy     = (state == ST_CALC);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            id           <= '0;
            n_reg        <= '0;
            i            <= '0;
            acc          <= '0;
            ack          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_id    <= '0;
        end else begin
            ack          <= '0;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        n_reg <= n_sel;
                        id    <= gidx;
                        ack   <= ONEHOT_0 << gidx;
                        acc   <= (n_sel == '0) ? '0 : ACC_ONE;
                        i     <= I_START;
                        ptr   <= ptr_next;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (i <= {1'b0, n_reg}) begin
                        acc <= acc * RW'(i);
                        i   <= i + 1'b1;
                    end else begin
                        result       <= acc;
                        result_id    <= id;
                        result_valid <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fact_rr_sched.md
Name: fact_rr_sched

Overview:
- Shares one iterative factorial engine (one 32-bit multiply per cycle) between NREQ requesters.
- Round-robin arbitration selects one request at a time. The block captures that requester's operand, sequences the multiply loop, and returns a tagged result.
- Sits between the control clients and the arithmetic datapath. It replaces per-client combinational factorial logic that would otherwise be unrolled.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NW, 4, operand width of n.
- RW, 32, result width; products are truncated modulo 2^RW.
- IDW, 2, result tag width; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  clock, all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  NREQ  per-requester request level.
- n_in  input  NREQ*NW  packed operands; requester k uses bits [k*NW +: NW].
- ack  output  NREQ  one-hot, one-cycle pulse: this requester's operand was captured.
- busy  output  1  high while the engine is not IDLE.
- result  output  RW  last completed factorial, held until the next completion.
- result_valid  output  1  one-cycle pulse marking a new result.
- result_id  output  IDW  index of the requester that owns result.

Behaviour:
- Reset (reset==0 at an edge) has priority over everything:
  - state=IDLE; ack=0, busy=0, result=0, result_valid=0, result_id=0.
  - Round-robin pointer ptr=0; acc, i, n_reg cleared.
  - Reset during CALC aborts the job. No result_valid is issued, and the aborted requester is not re-acked.
- Function: f(0)=0, f(1)=1, f(n)=n! mod 2^RW for n>=2. The n=0 -> 0 value is the team's fixed convention.
- States: IDLE and CALC.
- IDLE:
  - If req!=0, grant g = the first set bit searching ptr, ptr+1, ... with wrap mod NREQ.
  - On that edge: n_reg<=n_in[g]; id<=g; ack<=onehot(g); acc<=(n==0)?0:1; i<=2; ptr<=(g+1) mod NREQ; state<=CALC.
  - If req==0, remain in IDLE with ack=0.
- CALC, each edge:
  - If i<=n_reg: acc<=acc*i (low RW bits kept); i<=i+1.
  - Otherwise: result<=acc; result_id<=id; result_valid<=1 for one cycle; state<=IDLE.
- Loop counter width: i is NW+1 bits, so n=2^NW-1 terminates without wrap.
- ack deasserts the cycle after it is asserted. busy = (state==CALC).
- Latency: result_valid rises max(n,1) cycles after the capture edge.
- Throughput: IDLE lasts one cycle minimum, so back-to-back grants are spaced max(n,1)+1 cycles apart.
- Requester protocol:
  - Hold req and n_in stable until ack is seen.
  - Deassert req the cycle after ack. A req still high then counts as a new request.
  - Dropping req before ack withdraws the request with no side effects.
- n_in changes after ack have no effect on the running job.
- Simultaneous requests: exactly one ack per grant. Losers keep waiting. No requester waits more than NREQ-1 grants.
- Requests arriving during CALC are only evaluated in IDLE, using the ptr value at that time.

Test Plan:
- Reset, then req[0]=1 with n=5 -> ack[0] pulses one cycle; busy high for 5 cycles; result_valid pulse with result=120, result_id=0.
- Boundary operands:
  - n=0 -> result 0 after 1 cycle.
  - n=1 -> result 1 after 1 cycle.
  - n=13 -> result 1932053504.
  - n=15 -> result 2004310016 after 15 cycles, with no hang.
- req=4'b1111 held continuously, all n=3 -> grants in order 0,1,2,3,0. Results 6 each, result_id matching grant order, grants spaced 4 cycles apart.
- ptr=2 after a grant to requester 1; then req[0] and req[3] asserted together -> requester 3 is granted first, then requester 0.
- reset driven low mid-CALC during n=10 -> no result_valid; outputs return to 0 and busy=0 on the next cycle. A following request for n=4 returns 24.
- req[2] pulsed for one cycle while busy, then withdrawn before IDLE -> no ack[2] and no result with result_id=2.
